// File: rtl/tim_capture_if.sv
// tim_capture_if: control, pin and capture-result signals of the input-capture unit.
interface tim_capture_if #(parameter int CNT_W = 16);
  logic [7:0] psc;
  logic [1:0] edge_sel;
  logic irq_en;
  logic start;
  logic cap_in;
  logic cap_clr;
  logic [CNT_W-1:0] cap_val;
  logic [CNT_W-1:0] cap_high;
  logic cap_valid;
  logic cap_ovf;
  logic cap_sat;
  logic cap_irq;
  modport master (
    output psc, edge_sel, irq_en, start, cap_in, cap_clr,
    input cap_val, cap_high, cap_valid, cap_ovf, cap_sat, cap_irq
  );
  modport slave (
    input psc, edge_sel, irq_en, start, cap_in, cap_clr,
    output cap_val, cap_high, cap_valid, cap_ovf, cap_sat, cap_irq
  );
endinterface

// File: rtl/tim_capture.sv
// tim_capture: measures prescaled ticks between selected cap_in edges, with valid/overflow/irq.
// Define TIM_CAPTURE_DUTY_EN to also report the high time of each period on cap_high.
module tim_capture #(
  parameter int CNT_W = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  tim_capture_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2;
  logic [1:0] state;
  logic [SYNC_STAGES-1:0] sync;
  logic hist, s, hit, tick, sat;
  logic [7:0] psc_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] sum;
  assign s = sync[SYNC_STAGES-1];
  assign hit = bus.edge_sel == 2'b01 ? (hist & ~s) : bus.edge_sel == 2'b10 ? (hist ^ s) : (s & ~hist);
  assign tick = psc_cnt >= bus.psc;
  assign sum = {1'b0, cnt} + (CNT_W+1)'(tick);
  // a count already pinned at all-ones may hide further ticks, so it reports as saturated too
  assign sat = sum[CNT_W] | (&cnt);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
      state <= IDLE;
      psc_cnt <= '0;
      cnt <= '0;
      bus.cap_val <= '0;
      bus.cap_valid <= 1'b0;
      bus.cap_ovf <= 1'b0;
      bus.cap_sat <= 1'b0;
      bus.cap_irq <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.cap_in};
      hist <= s;
      bus.cap_irq <= 1'b0;
      if (bus.cap_clr) begin
        bus.cap_valid <= 1'b0;
        bus.cap_ovf <= 1'b0;
      end
      if (!bus.start) begin
        state <= IDLE;
        psc_cnt <= '0;
        cnt <= '0;
      end else if (state == IDLE) begin
        state <= ARM;
      end else begin
        psc_cnt <= (hit || tick) ? '0 : psc_cnt + 8'd1;
        if (hit) begin
          state <= RUN;
          cnt <= '0;
          if (state == RUN) begin
            bus.cap_val <= sat ? '1 : sum[CNT_W-1:0];
            bus.cap_sat <= sat;
            bus.cap_valid <= 1'b1;
            bus.cap_ovf <= bus.cap_valid & ~bus.cap_clr;
            bus.cap_irq <= bus.irq_en;
          end
        end else if (tick && state == RUN && !(&cnt)) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
`ifdef TIM_CAPTURE_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic lvl, hinc;
  logic [CNT_W:0] hsum;
  // hist is the level held during the cycle a tick accounts for
  assign hinc = tick & (hist == lvl);
  assign hsum = {1'b0, hcnt} + (CNT_W+1)'(hinc);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      lvl <= 1'b0;
      bus.cap_high <= '0;
    end else if (!bus.start || state == IDLE) begin
      hcnt <= '0;
    end else if (hit) begin
      hcnt <= '0;
      lvl <= s;
      if (state == RUN) bus.cap_high <= hsum[CNT_W] ? '1 : hsum[CNT_W-1:0];
    end else if (state == RUN && hinc && !(&hcnt)) begin
      hcnt <= hcnt + CNT_W'(1);
    end
  end
`else
  assign bus.cap_high = '0;
`endif
endmodule

// File: tb/tb_tim_capture.sv
// tb_tim_capture: directed stimulus against a period/tick-arithmetic model of tim_capture.
module tb_tim_capture;
  localparam int S = 2;
  localparam int W = 8;
  localparam int MAX = 255;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int lat;
  tim_capture_if #(.CNT_W(W)) bus();
  tim_capture #(.CNT_W(W), .SYNC_STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [S:0] dl;
  int mode, k, hk;
  logic lvl_m;
  logic [W-1:0] m_val, m_high;
  logic m_valid, m_ovf, m_sat, m_irq;
  logic m_hit, m_et;
  int m_n, m_t, m_inc;

  function automatic logic [W-1:0] clip(int t);
    return (t > MAX) ? W'(MAX) : W'(t);
  endfunction

  always_comb begin
    m_hit = bus.edge_sel == 2'b01 ? (dl[S] && !dl[S-1]) :
            bus.edge_sel == 2'b10 ? (dl[S] != dl[S-1]) : (dl[S-1] && !dl[S]);
    m_n = k + 1;
    m_t = m_n / (int'(bus.psc) + 1);
    m_et = (m_n % (int'(bus.psc) + 1)) == 0;
    m_inc = (m_et && dl[S] == lvl_m) ? 1 : 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl <= '0;
      mode <= 0;
      k <= 0;
      hk <= 0;
      lvl_m <= 1'b0;
      m_val <= '0;
      m_high <= '0;
      m_valid <= 1'b0;
      m_ovf <= 1'b0;
      m_sat <= 1'b0;
      m_irq <= 1'b0;
    end else begin
      dl <= {dl[S-1:0], bus.cap_in};
      m_irq <= 1'b0;
      if (bus.cap_clr) begin
        m_valid <= 1'b0;
        m_ovf <= 1'b0;
      end
      if (!bus.start) mode <= 0;
      else if (mode == 0) mode <= 1;
      else if (m_hit) begin
        if (mode == 2) begin
          m_val <= clip(m_t);
          m_sat <= (m_t > MAX) || (m_t == MAX && !m_et);
`ifdef TIM_CAPTURE_DUTY_EN
          m_high <= clip(hk + m_inc);
`endif
          m_valid <= 1'b1;
          m_ovf <= m_valid && !bus.cap_clr;
          m_irq <= bus.irq_en;
        end
        mode <= 2;
        k <= 0;
        hk <= 0;
        lvl_m <= dl[S-1];
      end else if (mode == 2) begin
        k <= k + 1;
        hk <= hk + m_inc;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cap_val", 32'(bus.cap_val), 32'(m_val));
    chk("cap_valid", 32'(bus.cap_valid), 32'(m_valid));
    chk("cap_ovf", 32'(bus.cap_ovf), 32'(m_ovf));
    chk("cap_sat", 32'(bus.cap_sat), 32'(m_sat));
    chk("cap_high", 32'(bus.cap_high), 32'(m_high));
    chk("cap_irq", 32'(bus.cap_irq), 32'(m_irq));
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic train(int period, int high, int n);
    repeat (n) begin
      bus.cap_in = 1'b1;
      cyc(high);
      bus.cap_in = 1'b0;
      cyc(period - high);
    end
  endtask

  initial begin
    bus.psc = 8'd0;
    bus.edge_sel = 2'b00;
    bus.irq_en = 1'b1;
    bus.start = 1'b1;
    bus.cap_in = 1'b0;
    bus.cap_clr = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 bus.cap_in = ~bus.cap_in;
    end
    chk("rst_val", 32'(bus.cap_val), 0);
    chk("rst_valid", 32'(bus.cap_valid), 0);
    chk("rst_irq", 32'(bus.cap_irq), 0);
    bus.start = 1'b0;
    bus.cap_in = 1'b0;
    cyc(4);
    rst_n = 1'b1;
    cyc(3);
    bus.start = 1'b1;
    cyc(2);
    train(100, 50, 1);
    chk("arm_no_capture", 32'(bus.cap_valid), 0);
    bus.cap_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.cap_irq) lat = i;
    end
    chk("irq_latency", lat, S + 2);
    chk("period_100", 32'(bus.cap_val), 100);
    chk("valid_100", 32'(bus.cap_valid), 1);
    @(posedge clk);
    #1;
    cyc(46);
    bus.cap_in = 1'b0;
    cyc(30);
    train(70, 35, 1);
    chk("ovf_val_latest", 32'(bus.cap_val), 80);
    chk("ovf_set", 32'(bus.cap_ovf), 1);
    bus.cap_in = 1'b1;
    cyc(S);
    bus.cap_clr = 1'b1;
    cyc(1);
    bus.cap_clr = 1'b0;
    cyc(35 - S - 1);
    bus.cap_in = 1'b0;
    cyc(35);
    chk("clr_coincident_val", 32'(bus.cap_val), 70);
    chk("clr_coincident_valid", 32'(bus.cap_valid), 1);
    chk("clr_coincident_ovf", 32'(bus.cap_ovf), 0);
    bus.cap_clr = 1'b1;
    cyc(1);
    bus.cap_clr = 1'b0;
    cyc(1);
    chk("clr_alone_valid", 32'(bus.cap_valid), 0);
    bus.start = 1'b0;
    cyc(2);
    bus.psc = 8'd3;
    bus.edge_sel = 2'b11;
    bus.irq_en = 1'b0;
    bus.start = 1'b1;
    cyc(2);
    train(400, 200, 3);
    chk("psc3_period", 32'(bus.cap_val), 100);
    bus.start = 1'b0;
    cyc(2);
    bus.psc = 8'd0;
    bus.edge_sel = 2'b10;
    bus.irq_en = 1'b1;
    bus.start = 1'b1;
    cyc(2);
    train(200, 60, 2);
    bus.cap_in = 1'b1;
    cyc(10);
    chk("both_low_seg", 32'(bus.cap_val), 140);
    cyc(50);
    bus.cap_in = 1'b0;
    cyc(140);
    chk("both_high_seg", 32'(bus.cap_val), 60);
`ifdef TIM_CAPTURE_DUTY_EN
    bus.start = 1'b0;
    cyc(2);
    bus.edge_sel = 2'b00;
    bus.start = 1'b1;
    cyc(2);
    train(200, 60, 3);
    chk("duty_high", 32'(bus.cap_high), 60);
    chk("duty_period", 32'(bus.cap_val), 200);
`endif
    bus.start = 1'b0;
    cyc(2);
    bus.edge_sel = 2'b01;
    bus.start = 1'b1;
    cyc(2);
    train(255, 100, 1);
    train(256, 100, 1);
    chk("period_255_val", 32'(bus.cap_val), 255);
    chk("period_255_sat", 32'(bus.cap_sat), 0);
    bus.cap_in = 1'b1;
    cyc(100);
    bus.cap_in = 1'b0;
    cyc(100);
    chk("period_256_val", 32'(bus.cap_val), 255);
    chk("period_256_sat", 32'(bus.cap_sat), 1);
    bus.start = 1'b0;
    cyc(2);
    bus.edge_sel = 2'b00;
    bus.start = 1'b1;
    cyc(2);
    train(300, 150, 1);
    train(50, 25, 1);
    chk("period_300_val", 32'(bus.cap_val), 255);
    chk("period_300_sat", 32'(bus.cap_sat), 1);
    bus.cap_in = 1'b1;
    cyc(25);
    bus.cap_in = 1'b0;
    cyc(20);
    chk("period_50_val", 32'(bus.cap_val), 50);
    chk("period_50_sat", 32'(bus.cap_sat), 0);
    bus.start = 1'b0;
    cyc(3);
    bus.cap_in = 1'b1;
    cyc(10);
    bus.cap_in = 1'b0;
    cyc(10);
    chk("idle_hold_val", 32'(bus.cap_val), 50);
    bus.start = 1'b1;
    cyc(2);
    train(40, 20, 2);
    chk("pre_reset_val", 32'(bus.cap_val), 40);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_val", 32'(bus.cap_val), 0);
    chk("midrst_valid", 32'(bus.cap_valid), 0);
    chk("midrst_ovf", 32'(bus.cap_ovf), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
